demux16_deser: RTL and testbench

- Inverse of the 16:1 bit-select mux. Takes one serial bit per accepted beat, steers it into a slot of a 16-bit frame, and publishes the assembled word once every slot has been filled.
- Sits on the receive side of a link whose transmitter serializes a 16-bit word through a 16:1 mux driven by a 4-bit select.
- Two steering modes:
  - Auto: an internal counter supplies the slot index.
  - Addressed: the transmitter's select value travels with each bit and supplies the slot index.

---
 rtl/demux16_deser.sv | 75 +++++++
 tb/tb_demux16_deser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux16_deser.sv
// demux16_deser: serial-to-parallel frame builder for a 16:1 mux link.
// Steers each accepted bit into a slot; publishes once all slots are filled.
module demux16_deser #(
   parameter int WIDTH = 16,
   parameter int SELW  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in,
   input  logic            in_valid,
   input  logic [SELW-1:0] sel,
   input  logic            mode,
   input  logic            clear,
   output logic [WIDTH-1:0] out,
   output logic            out_valid,
   output logic [SELW-1:0] slot,
   output logic            busy
);

   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] bitsel;
   logic [WIDTH-1:0] nshadow;
   logic [WIDTH-1:0] nmask;
   logic [SELW-1:0]  idx;
   logic             lmode;
   logic             amode;
   logic             full;

   assign busy = |mask;

   // Steering for this beat; the first bit of a frame sees the live mode.
   always_comb begin
      amode   = busy ? lmode : mode;
      idx     = amode ? sel : slot;
      bitsel  = WIDTH'(1) << idx;
      nmask   = mask | bitsel;
      nshadow = in ? (shadow | bitsel) : (shadow & ~bitsel);
      full    = &nmask;
   end

   // Frame assembly, publish and flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         slot      <= '0;
         shadow    <= '0;
         mask      <= '0;
         lmode     <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (clear) begin
            mask   <= '0;
            shadow <= '0;
            slot   <= '0;
         end else if (in_valid) begin
            if (!busy)
               lmode <= mode;
            if (!amode)
               slot <= slot + SELW'(1);
            if (full) begin
               out       <= nshadow;
               out_valid <= 1'b1;
               mask      <= '0;
               shadow    <= '0;
            end else begin
               mask   <= nmask;
               shadow <= nshadow;
            end
         end
      end
   end

endmodule

// File: tb/tb_demux16_deser.sv
// tb_demux16_deser: directed and randomized checks of demux16_deser
// against a slot/count frame model.
module tb_demux16_deser;

   logic        clk;
   logic        rst;
   logic        in;
   logic        in_valid;
   logic [3:0]  sel;
   logic        mode;
   logic        clear;
   logic [15:0] out;
   logic        out_valid;
   logic [3:0]  slot;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_out;
   logic [15:0] m_frame;
   bit          m_got [16];
   int          m_cnt;
   int          m_slot;
   bit          m_am;
   bit          m_ov;

   demux16_deser #(.WIDTH(16), .SELW(4)) dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
      .sel(sel), .mode(mode), .clear(clear), .out(out),
      .out_valid(out_valid), .slot(slot), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_step(logic r, logic c, logic v,
                                      logic b, logic [3:0] s, logic md);
      int k;
      m_ov = 1'b0;
      if (r) begin
         m_out = '0; m_frame = '0; m_cnt = 0; m_slot = 0; m_am = 1'b0;
         foreach (m_got[j]) m_got[j] = 1'b0;
      end else if (c) begin
         m_frame = '0; m_cnt = 0; m_slot = 0;
         foreach (m_got[j]) m_got[j] = 1'b0;
      end else if (v) begin
         if (m_cnt == 0) m_am = md;
         k = m_am ? int'(s) : m_slot;
         if (!m_am) m_slot = (m_slot + 1) % 16;
         m_frame[k] = b;
         if (!m_got[k]) begin
            m_got[k] = 1'b1;
            m_cnt++;
         end
         if (m_cnt == 16) begin
            m_out = m_frame; m_ov = 1'b1; m_cnt = 0;
            foreach (m_got[j]) m_got[j] = 1'b0;
         end
      end
   endfunction

   task automatic drive(input logic r, input logic c, input logic v,
                        input logic b, input logic [3:0] s, input logic md);
      @(negedge clk);
      rst = r; clear = c; in_valid = v; in = b; sel = s; mode = md;
      @(posedge clk);
      model_step(r, c, v, b, s, md);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 1, 4'h7, 1);
      total++;
      if (out !== 16'h0 || out_valid !== 1'b0 || slot !== 4'h0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset: out=%h ov=%b slot=%h busy=%b want 0 0 0 0",
                  out, out_valid, slot, busy);
      end
   endtask

   task automatic test_auto();
      logic [15:0] p = 16'hF0A5;
      int pulses = 0;
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 1, p[i], 4'($urandom), 0);
         if (out_valid) pulses++;
         total++;
         if (out_valid !== (i == 15) || slot !== 4'(m_slot) || busy !== (m_cnt != 0)) begin
            bad++;
            $display("FAIL auto[%0d]: ov=%b slot=%h busy=%b want ov=%b slot=%h busy=%b",
                     i, out_valid, slot, busy, i == 15, 4'(m_slot), m_cnt != 0);
         end
      end
      total++;
      if (out !== 16'hF0A5 || slot !== 4'h0 || busy !== 1'b0 || pulses != 1) begin
         bad++;
         $display("FAIL auto_pub: out=%h slot=%h busy=%b pulses=%0d want f0a5 0 0 1",
                  out, slot, busy, pulses);
      end
      drive(0, 0, 0, 0, 0, 0);
      total++;
      if (out_valid !== 1'b0 || out !== 16'hF0A5) begin
         bad++;
         $display("FAIL auto_hold: out=%h ov=%b want f0a5 0", out, out_valid);
      end
   endtask

   task automatic test_addressed();
      logic [15:0] p = 16'hF0A5;
      int pulses = 0;
      for (int s = 15; s >= 0; s--) begin
         drive(0, 0, 1, p[s], 4'(s), 1);
         if (out_valid) pulses++;
         total++;
         if (out_valid !== (s == 0) || slot !== 4'h0) begin
            bad++;
            $display("FAIL addr[%0d]: ov=%b slot=%h want ov=%b slot=0",
                     s, out_valid, slot, s == 0);
         end
         if (s == 0) begin
            total++;
            if (out !== 16'hF0A5) begin
               bad++;
               $display("FAIL addr_out: out=%h want f0a5", out);
            end
         end
         for (int g = 0; g < 2; g++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (out_valid) pulses++;
         end
      end
      total++;
      if (pulses != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL addr_pulses: pulses=%0d busy=%b want 1 0", pulses, busy);
      end
   endtask

   task automatic test_dup();
      drive(0, 0, 1, 1, 4'd3, 1);
      drive(0, 0, 1, 0, 4'd3, 1);
      for (int s = 0; s < 16; s++) begin
         if (s == 3) continue;
         drive(0, 0, 1, 1, 4'(s), 1);
         total++;
         if (out_valid !== (s == 15)) begin
            bad++;
            $display("FAIL dup[%0d]: ov=%b want %b", s, out_valid, s == 15);
         end
      end
      total++;
      if (out !== 16'hFFF7 || out !== m_out) begin
         bad++;
         $display("FAIL dup_out: out=%h want fff7", out);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] p = {16'h0F5A, 16'hF0A5};
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 1, p[i], 0, 0);
         total++;
         if (out_valid !== (i == 15 || i == 31)) begin
            bad++;
            $display("FAIL b2b_ov[%0d]: ov=%b want %b", i, out_valid, i == 15 || i == 31);
         end
         if (i == 15 || i == 31) begin
            total++;
            if (out !== ((i == 15) ? 16'hF0A5 : 16'h0F5A)) begin
               bad++;
               $display("FAIL b2b_out[%0d]: out=%h want %h", i, out,
                        (i == 15) ? 16'hF0A5 : 16'h0F5A);
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [15:0] prev = out;
      logic [15:0] d = 16'($urandom);
      for (int i = 0; i < 7; i++) drive(0, 0, 1, 1'($urandom), 0, 0);
      drive(0, 1, 1, 1, 0, 0);
      total++;
      if (busy !== 1'b0 || slot !== 4'h0 || out !== prev || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL clear: busy=%b slot=%h out=%h ov=%b want 0 0 %h 0",
                  busy, slot, out, out_valid, prev);
      end
      for (int i = 0; i < 16; i++) drive(0, 0, 1, d[i], 0, 0);
      total++;
      if (out !== d || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL clear_next: out=%h ov=%b want %h 1", out, out_valid, d);
      end
      for (int i = 0; i < 7; i++) drive(0, 0, 1, 1'($urandom), 0, 0);
      drive(1, 1, 1, 1, 0, 0);
      total++;
      if (busy !== 1'b0 || slot !== 4'h0 || out !== 16'h0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: busy=%b slot=%h out=%h ov=%b want 0 0 0 0",
                  busy, slot, out, out_valid);
      end
   endtask

   task automatic test_mode_change();
      logic [15:0] d = 16'($urandom);
      logic [15:0] e = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 1, d[i], 0, (i >= 4));
         total++;
         if (out_valid !== (i == 15) || slot !== 4'((i + 1) % 16)) begin
            bad++;
            $display("FAIL mchg[%0d]: ov=%b slot=%h want %b %h",
                     i, out_valid, slot, i == 15, 4'((i + 1) % 16));
         end
      end
      total++;
      if (out !== d) begin
         bad++;
         $display("FAIL mchg_out: out=%h want %h", out, d);
      end
      for (int s = 15; s >= 0; s--) begin
         drive(0, 0, 1, e[s], 4'(s), 1);
         total++;
         if (slot !== 4'h0 || out_valid !== (s == 0)) begin
            bad++;
            $display("FAIL mchg_addr[%0d]: slot=%h ov=%b want 0 %b",
                     s, slot, out_valid, s == 0);
         end
      end
      total++;
      if (out !== e) begin
         bad++;
         $display("FAIL mchg_addr_out: out=%h want %h", out, e);
      end
   endtask

   task automatic test_random();
      logic md = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) md = ~md;
         drive(($urandom_range(0, 127) == 0), ($urandom_range(0, 47) == 0),
               1'($urandom), 1'($urandom), 4'($urandom), md);
         total++;
         if (out !== m_out || out_valid !== m_ov || slot !== 4'(m_slot) ||
             busy !== (m_cnt != 0)) begin
            bad++;
            $display("FAIL rand[%0d]: out=%h ov=%b slot=%h busy=%b want %h %b %h %b",
                     i, out, out_valid, slot, busy, m_out, m_ov, 4'(m_slot), m_cnt != 0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in = 1'b0;
      sel = 4'h0; mode = 1'b0;
      test_reset();
      test_auto();
      test_addressed();
      test_dup();
      test_back_to_back();
      test_flush();
      test_mode_change();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
